mdu_stall_ctrl: RTL and testbench
=================================

Name: mdu_stall_ctrl

Overview:
- Scheduler for the shared multiply/divide unit (MDU) and its HI/LO registers in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu issued from E and tracks their multi-cycle latency.
- Merges MDU-use conflicts with the hazard unit's register stall into the single stall that holds F/D and bubbles the D/E register.
- Cancels issue on an exception/interrupt flush (Req).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu. Range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu. Range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Req  in  1  exception/interrupt flush from CP0. Same cycle the pipeline registers load the handler PC.
- start_E  in  1  valid mult/multu/div/divu in E (not a bubble).
- op_E  in  2  00 mult, 01 multu, 10 div, 11 divu.
- mt_E  in  1  valid mthi/mtlo in E.
- md_use_D  in  1  D-stage instr is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- hz_stall  in  1  register-dependency stall from hazard unit.
- stall  out  1  to F/D hold and D/E stall input.
- busy  out  1  MDU computation in flight.
- cnt  out  4  remaining busy cycles.
- mdu_go  out  1  latch operands/op into MDU datapath this cycle.
- hilo_we  out  1  commit MDU result to HI/LO this cycle.
- mt_we  out  1  commit mthi/mtlo this cycle.
- op_q  out  2  latched op of in-flight operation.

Behaviour:
- Reset (async): state=IDLE, cnt=0, busy=0, hilo_we=0, op_q=00. Combinational outputs follow inputs.
- States: IDLE and RUN. busy = (state==RUN).
- Issue rule:
  - issue = start_E & ~Req & ~busy.
  - mdu_go = issue (combinational, same cycle).
  - On issue, at the next edge: state=RUN, op_q=op_E, cnt = MULT_CYCLES if op_E[1]==0, else DIV_CYCLES.
- RUN:
  - cnt decrements by 1 each edge.
  - When cnt==1 at an edge: state goes to IDLE, cnt=0.
  - hilo_we is registered and high for exactly the one cycle after that edge, i.e. the first IDLE cycle.
- Latency: issue in cycle T gives busy high for cycles T+1..T+N, with hilo_we=1 in cycle T+N+1 (N = configured cycles).
- start_E while busy: illegal, since the D-side stall prevents it. Ignore it, count no new op, and flag with an assertion.
- mt_we = mt_E & ~Req & ~busy.
- Stall:
  - stall = ~Req & (hz_stall | (md_use_D & (busy | start_E | hilo_we))).
  - The hilo_we term keeps mfhi/mflo from reading HI/LO before the commit cycle.
- Req priority:
  - Req in the issue cycle suppresses mdu_go and keeps the state IDLE, because the E-stage op is younger than the faulting instruction.
  - Req during RUN does not abort. The op already left E and is older, so it runs to completion and hilo_we still fires.
  - stall is forced to 0 while Req is high, so the flush wins over the hold.
- Reset mid-RUN: immediate return to IDLE, cnt=0, and no hilo_we pulse.
- Counter never wraps: it decrements only in RUN and cnt≥1 there.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - the state enum {IDLE, RUN};
  - default cycle constants 5 and 10.
- No sub-module. The FSM plus 4-bit down-counter stays in one module.

Test Plan:
- Reset asserted mid-RUN (cnt=3), async: busy=0, cnt=0 immediately, no hilo_we afterwards.
- start_E=1, op_E=00, Req=0 at cycle 0: mdu_go=1 at cycle 0; busy=1 cycles 1..5; cnt 5,4,3,2,1; hilo_we=1 only at cycle 6.
- div issue at cycle 0 with md_use_D=1 (mflo) throughout: stall=1 cycles 0..11, stall=0 at cycle 12, hilo_we=1 at cycle 11.
- start_E=1 with Req=1 in the same cycle: mdu_go=0, busy stays 0, stall=0, no hilo_we.
- Req=1 at cycle 3 of a mult: busy persists to cycle 5, hilo_we=1 at cycle 6, stall=0 in cycle 3.
- hz_stall=1 with MDU idle and md_use_D=0: stall=1. mt_E=1 while idle: mt_we=1 the same cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit scheduler.
package mdu_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {IDLE, RUN} mdu_state_e;
endpackage

// File: rtl/mdu_stall_ctrl.sv
// MDU issue/latency tracker and the merged F/D hold + D/E bubble stall.
module mdu_stall_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic       start_E,
  input  logic [1:0] op_E,
  input  logic       mt_E,
  input  logic       md_use_D,
  input  logic       hz_stall,
  output logic       stall,
  output logic       busy,
  output logic [3:0] cnt,
  output logic       mdu_go,
  output logic       hilo_we,
  output logic       mt_we,
  output logic [1:0] op_q
);

  mdu_state_e state_q;
  logic [3:0] cnt_q;
  logic       hilo_we_q;
  logic [1:0] op_lat_q;
  logic       issue;
  logic [3:0] load_cnt;

  assign busy     = (state_q == RUN);
  assign cnt      = cnt_q;
  assign hilo_we  = hilo_we_q;
  assign op_q     = op_lat_q;

  // A flush cancels the E-stage op: it is younger than the faulting instruction.
  assign issue    = start_E & ~Req & ~busy;
  assign mdu_go   = issue;
  assign mt_we    = mt_E & ~Req & ~busy;
  assign load_cnt = op_E[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // hilo_we term holds mfhi/mflo in D until the commit cycle has passed.
  assign stall = ~Req & (hz_stall | (md_use_D & (busy | start_E | hilo_we_q)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hilo_we_q <= 1'b0;
      op_lat_q  <= OP_MULT;
    end else begin
      hilo_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q  <= RUN;
            op_lat_q <= op_E;
            cnt_q    <= load_cnt;
          end
        end
        RUN: begin
          // An in-flight op is older than any flush, so Req never aborts it.
          if (cnt_q == 4'd1) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hilo_we_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (reset) !(start_E && busy)
  ) else $error("mdu_stall_ctrl: start_E while MDU busy");

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Randomized + directed check of mdu_stall_ctrl against an issue-time/latency model.
module tb_mdu_stall_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset, Req, start_E, mt_E, md_use_D, hz_stall;
  logic [1:0] op_E;
  logic       stall, busy, mdu_go, hilo_we, mt_we;
  logic [3:0] cnt;
  logic [1:0] op_q;

  mdu_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Req(Req), .start_E(start_E), .op_E(op_E),
    .mt_E(mt_E), .md_use_D(md_use_D), .hz_stall(hz_stall), .stall(stall),
    .busy(busy), .cnt(cnt), .mdu_go(mdu_go), .hilo_we(hilo_we),
    .mt_we(mt_we), .op_q(op_q)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  // Model: the last accepted op issued in cycle T with latency N.
  int cyc = 0;
  bit has_op = 0;
  int T = 0, N = 0;
  logic [1:0] exp_op = 2'b00;

  function automatic bit m_busy();
    return has_op && (cyc >= T + 1) && (cyc <= T + N);
  endfunction
  function automatic int m_cnt();
    return m_busy() ? (T + N + 1 - cyc) : 0;
  endfunction
  function automatic bit m_hilo();
    return has_op && (cyc == T + N + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check all outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input bit st, input logic [1:0] op, input bit rq,
                       input bit mt, input bit mu, input bit hz);
    bit b, iss, h;
    start_E = st; op_E = op; Req = rq; mt_E = mt; md_use_D = mu; hz_stall = hz;
    #1;
    b = m_busy(); h = m_hilo();
    iss = st & ~rq & ~b;
    chk("busy",    32'(busy),    32'(b));
    chk("cnt",     32'(cnt),     32'(m_cnt()));
    chk("hilo_we", 32'(hilo_we), 32'(h));
    chk("mdu_go",  32'(mdu_go),  32'(iss));
    chk("mt_we",   32'(mt_we),   32'(mt & ~rq & ~b));
    chk("stall",   32'(stall),   32'(~rq & (hz | (mu & (b | st | h)))));
    chk("op_q",    32'(op_q),    32'(exp_op));
    @(posedge clk);
    if (iss) begin
      has_op = 1; T = cyc; N = op[1] ? DC : MC; exp_op = op;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; Req = 0; start_E = 0; op_E = 0; mt_E = 0; md_use_D = 0; hz_stall = 0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt",  32'(cnt), 0);
    chk("rst_hilo", 32'(hilo_we), 0);
    chk("rst_opq",  32'(op_q), 0);
    @(negedge clk);
    reset = 0;

    // mult issue: busy 5 cycles, commit on the 6th
    cycle(1, 2'b00, 0, 0, 0, 0);
    idle(7);
    // div with mflo waiting in D throughout
    cycle(1, 2'b10, 0, 0, 1, 0);
    for (int i = 0; i < 13; i++) cycle(0, 2'b00, 0, 0, 1, 0);
    // issue coinciding with flush is dropped
    cycle(1, 2'b11, 1, 0, 1, 0);
    idle(3);
    // Req mid-mult does not abort
    cycle(1, 2'b01, 0, 0, 1, 0);
    cycle(0, 2'b00, 0, 0, 1, 0);
    cycle(0, 2'b00, 0, 0, 1, 0);
    cycle(0, 2'b00, 1, 0, 1, 1);
    idle(5);
    // register stall alone, and mthi/mtlo while idle
    cycle(0, 2'b00, 0, 0, 0, 1);
    cycle(0, 2'b00, 0, 1, 0, 0);

    // async reset mid-RUN at cnt=3
    cycle(1, 2'b00, 0, 0, 0, 0);
    idle(2);
    #1;
    chk("pre_rst_cnt", 32'(cnt), 3);
    reset = 1;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_cnt",  32'(cnt), 0);
    chk("async_hilo", 32'(hilo_we), 0);
    has_op = 0; exp_op = 2'b00;
    @(negedge clk);
    reset = 0;
    idle(8);

    // randomized traffic; start_E only offered when the model says idle
    for (int i = 0; i < 400; i++) begin
      bit st, rq;
      logic [1:0] op;
      st = ($urandom_range(0, 2) == 0) && !m_busy();
      rq = ($urandom_range(0, 7) == 0);
      op = 2'($urandom);
      cycle(st, op, rq, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
